// File: rtl/vga_text_fetch_if.sv
// Port-2 text-buffer and font-ROM read bus used by the VGA text fetch engine.
interface vga_text_fetch_if;
    logic [11:0] text_address;
    logic        text_chipselect;
    logic        text_write;
    logic [7:0]  text_writedata;
    logic        text_clken;
    logic [7:0]  text_readdata;
    logic [11:0] font_address;
    logic [7:0]  font_readdata;

    modport master (
        output text_address, text_chipselect, text_write, text_writedata, text_clken,
        output font_address,
        input  text_readdata, font_readdata
    );

    modport slave (
        input  text_address, text_chipselect, text_write, text_writedata, text_clken,
        input  font_address,
        output text_readdata, font_readdata
    );
endinterface

// File: rtl/vga_text_fetch.sv
// Text-mode read engine: pixel coordinates -> text buffer -> font ROM -> RGB,
// with a fixed 3-cycle pipeline and a frame-counted blinking underline cursor.
module vga_text_fetch #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    vga_text_fetch_if.master  mem,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [6:0]        col;
    logic [5:0]        row;
    logic              in_area;
    logic              cursor_hit;
    logic [ADDR_W-1:0] cell_addr;

    // Stage 0: cell decode and buffer address
    always_comb begin
        col        = pix_x[9:3];
        row        = pix_y[9:4];
        in_area    = de_in && (32'(col) < COLS) && (32'(row) < ROWS);
        cell_addr  = ADDR_W'(32'(row) * COLS + 32'(col));
        cursor_hit = cursor_en && in_area && (col == cursor_col)
                     && (row == 6'(cursor_row)) && (pix_y[3:0] >= 4'd14);
    end

    assign mem.text_address    = in_area ? cell_addr : '0;
    assign mem.text_chipselect = in_area;
    assign mem.text_write      = 1'b0;
    assign mem.text_writedata  = '0;
    assign mem.text_clken      = 1'b1;

    logic [2:0] bitidx_s1, bitidx_s2;
    logic [3:0] yrow_s1;
    logic       in_area_s1, in_area_s2;
    logic       cursor_hit_s1, cursor_hit_s2;
    logic       de_s1, de_s2, hs_s1, hs_s2, vs_s1, vs_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitidx_s1     <= '0;
            yrow_s1       <= '0;
            in_area_s1    <= 1'b0;
            cursor_hit_s1 <= 1'b0;
            de_s1         <= 1'b0;
            hs_s1         <= 1'b1;
            vs_s1         <= 1'b1;
            bitidx_s2     <= '0;
            in_area_s2    <= 1'b0;
            cursor_hit_s2 <= 1'b0;
            de_s2         <= 1'b0;
            hs_s2         <= 1'b1;
            vs_s2         <= 1'b1;
        end else begin
            bitidx_s1     <= pix_x[2:0];
            yrow_s1       <= pix_y[3:0];
            in_area_s1    <= in_area;
            cursor_hit_s1 <= cursor_hit;
            de_s1         <= de_in;
            hs_s1         <= hsync_in;
            vs_s1         <= vsync_in;
            bitidx_s2     <= bitidx_s1;
            in_area_s2    <= in_area_s1;
            cursor_hit_s2 <= cursor_hit_s1;
            de_s2         <= de_s1;
            hs_s2         <= hs_s1;
            vs_s2         <= vs_s1;
        end
    end

    // Stage 1: glyph row lookup for the character just read
    assign mem.font_address = {mem.text_readdata, yrow_s1};

    // Cursor blink: count vsync falling edges, toggle phase on wrap
    logic             vs_prev;
    logic             blink_phase;
    logic [CNT_W-1:0] frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev     <= 1'b1;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (vs_prev && !vsync_in) begin
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 2: pixel select and colour map
    logic        pixel;
    logic [23:0] rgb;

    always_comb begin
        pixel = mem.font_readdata[3'd7 - bitidx_s2] | (cursor_hit_s2 & blink_phase);
        rgb   = in_area_s2 ? (pixel ? FG_RGB : BG_RGB) : 24'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {vga_r, vga_g, vga_b} <= 24'h0;
            vga_de                <= 1'b0;
            vga_hs                <= 1'b1;
            vga_vs                <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb;
            vga_de                <= de_s2;
            vga_hs                <= hs_s2;
            vga_vs                <= vs_s2;
        end
    end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch with 1-cycle text-buffer and font-ROM models.
module tb_vga_text_fetch;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic       clk;
    logic       reset_n;
    logic [9:0] pix_x, pix_y;
    logic       de_in, hsync_in, vsync_in;
    logic       cursor_en;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de;

    vga_text_fetch_if bus ();

    vga_text_fetch #(
        .COLS(80), .ROWS(30), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_x(pix_x), .pix_y(pix_y),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem(bus.master),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] text_mem [0:4095];
    logic [7:0] font_mem [0:4095];

    always @(posedge clk) begin
        if (bus.text_chipselect && bus.text_clken)
            bus.text_readdata <= text_mem[bus.text_address];
        bus.font_readdata <= font_mem[bus.font_address];
    end

    int errors = 0;
    int checks = 0;
    int n = 0;
    int last = 0;
    logic [23:0] hist_rgb [0:1023];
    logic        hist_de  [0:1023];
    logic        hist_hs  [0:1023];
    logic        hist_vs  [0:1023];

    // Sample outputs at the falling edge, then apply the next pixel's inputs
    task automatic tick(input int x, input int y, input logic de, input logic hs, input logic vs);
        @(negedge clk);
        hist_rgb[n] = {vga_r, vga_g, vga_b};
        hist_de[n]  = vga_de;
        hist_hs[n]  = vga_hs;
        hist_vs[n]  = vga_vs;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        last = n;
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic vs_pulse();
        tick(0, 0, 1'b0, 1'b1, 1'b0);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        idle(2);
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs} !== {24'h0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got rgb=%h de=%b hs=%b vs=%b, want 000000 0 1 1",
                     {vga_r, vga_g, vga_b}, vga_de, vga_hs, vga_vs);
        end
        checks++;
        if ({bus.text_write, bus.text_writedata, bus.text_clken} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL tie_offs: got write=%b wdata=%h clken=%b, want 0 00 1",
                     bus.text_write, bus.text_writedata, bus.text_clken);
        end
        tick(0, 0, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.text_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL cs_during_reset: got %b, want 1", bus.text_chipselect);
        end
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        reset_n = 1'b1;
        idle(3);
    endtask

    task automatic test_char_row();
        int k0;
        logic [7:0] glyph;
        logic [23:0] exp;
        glyph = 8'h18;
        idle(1);
        k0 = n;
        for (int x = 0; x < 8; x++) begin
            tick(x, 0, 1'b1, 1'b1, 1'b1);
            #1;
            if (x == 0) begin
                checks++;
                if (bus.text_address !== 12'h000 || bus.text_chipselect !== 1'b1) begin
                    errors++;
                    $display("FAIL char_addr: got addr=%h cs=%b, want 000 1",
                             bus.text_address, bus.text_chipselect);
                end
            end
            if (x == 1) begin
                checks++;
                if (bus.font_address !== 12'h410) begin
                    errors++;
                    $display("FAIL char_font_addr: got %h, want 410", bus.font_address);
                end
            end
        end
        idle(4);
        checks++;
        if (hist_de[k0+2] !== 1'b0 || hist_de[k0+3] !== 1'b1) begin
            errors++;
            $display("FAIL char_de_latency: got de[+2]=%b de[+3]=%b, want 0 1",
                     hist_de[k0+2], hist_de[k0+3]);
        end
        for (int i = 0; i < 8; i++) begin
            exp = glyph[7-i] ? FG : BG;
            checks++;
            if (hist_rgb[k0+3+i] !== exp) begin
                errors++;
                $display("FAIL char_pixel x=%0d: got %h, want %h", i, hist_rgb[k0+3+i], exp);
            end
        end
    endtask

    task automatic test_last_cell();
        int k0;
        tick(639, 479, 1'b1, 1'b1, 1'b1);
        k0 = last;
        #1;
        checks++;
        if (bus.text_address !== 12'h95F || bus.text_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL last_cell_addr: got addr=%h cs=%b, want 95f 1",
                     bus.text_address, bus.text_chipselect);
        end
        tick(636, 479, 1'b1, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (hist_rgb[k0+3] !== FG || hist_de[k0+3] !== 1'b1) begin
            errors++;
            $display("FAIL last_cell_x639: got rgb=%h de=%b, want %h 1", hist_rgb[k0+3], hist_de[k0+3], FG);
        end
        checks++;
        if (hist_rgb[k0+4] !== BG) begin
            errors++;
            $display("FAIL last_cell_x636: got %h, want %h", hist_rgb[k0+4], BG);
        end
    endtask

    task automatic test_out_of_range();
        int k0;
        tick(700, 0, 1'b0, 1'b1, 1'b1);
        k0 = last;
        #1;
        checks++;
        if (bus.text_chipselect !== 1'b0 || bus.text_address !== 12'h000) begin
            errors++;
            $display("FAIL oor_de0: got cs=%b addr=%h, want 0 000", bus.text_chipselect, bus.text_address);
        end
        tick(640, 5, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.text_chipselect !== 1'b0 || bus.text_address !== 12'h000) begin
            errors++;
            $display("FAIL oor_x640: got cs=%b addr=%h, want 0 000", bus.text_chipselect, bus.text_address);
        end
        tick(100, 480, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.text_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL oor_y480: got cs=%b, want 0", bus.text_chipselect);
        end
        idle(4);
        checks++;
        if (hist_rgb[k0+3] !== 24'h0 || hist_de[k0+3] !== 1'b0) begin
            errors++;
            $display("FAIL oor_de0_out: got rgb=%h de=%b, want 000000 0", hist_rgb[k0+3], hist_de[k0+3]);
        end
        checks++;
        if (hist_rgb[k0+4] !== 24'h0 || hist_de[k0+4] !== 1'b1) begin
            errors++;
            $display("FAIL oor_x640_out: got rgb=%h de=%b, want 000000 1", hist_rgb[k0+4], hist_de[k0+4]);
        end
    endtask

    task automatic test_sync_delay();
        int kh, kv;
        idle(1);
        tick(0, 0, 1'b0, 1'b0, 1'b1);
        kh = last;
        idle(1);
        tick(0, 0, 1'b0, 1'b1, 1'b0);
        kv = last;
        idle(5);
        checks++;
        if ({hist_hs[kh+2], hist_hs[kh+3], hist_hs[kh+4]} !== 3'b101) begin
            errors++;
            $display("FAIL hsync_delay: got %b%b%b, want 101", hist_hs[kh+2], hist_hs[kh+3], hist_hs[kh+4]);
        end
        checks++;
        if ({hist_vs[kv+2], hist_vs[kv+3], hist_vs[kv+4]} !== 3'b101) begin
            errors++;
            $display("FAIL vsync_delay: got %b%b%b, want 101", hist_vs[kv+2], hist_vs[kv+3], hist_vs[kv+4]);
        end
    endtask

    task automatic test_cursor_blink();
        int k0, k45, k48, kb;
        @(negedge clk);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        cursor_en  = 1'b1;
        cursor_col = 7'd5;
        cursor_row = 5'd2;
        idle(1);
        k0 = n;
        for (int x = 40; x < 48; x++) begin
            tick(x, 46, 1'b1, 1'b1, 1'b1);
            if (x == 40) begin
                #1;
                checks++;
                if (bus.text_address !== 12'd165) begin
                    errors++;
                    $display("FAIL cursor_cell_addr: got %0d, want 165", bus.text_address);
                end
            end
        end
        tick(40, 45, 1'b1, 1'b1, 1'b1);
        k45 = last;
        tick(48, 46, 1'b1, 1'b1, 1'b1);
        k48 = last;
        idle(4);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (hist_rgb[k0+3+i] !== FG) begin
                errors++;
                $display("FAIL cursor_on x=%0d: got %h, want %h", 40 + i, hist_rgb[k0+3+i], FG);
            end
        end
        checks++;
        if (hist_rgb[k45+3] !== BG) begin
            errors++;
            $display("FAIL cursor_y45: got %h, want %h", hist_rgb[k45+3], BG);
        end
        checks++;
        if (hist_rgb[k48+3] !== BG) begin
            errors++;
            $display("FAIL cursor_next_cell: got %h, want %h", hist_rgb[k48+3], BG);
        end
        vs_pulse();
        vs_pulse();
        tick(41, 47, 1'b1, 1'b1, 1'b1);
        kb = last;
        idle(4);
        checks++;
        if (hist_rgb[kb+3] !== BG) begin
            errors++;
            $display("FAIL cursor_blink_off: got %h, want %h", hist_rgb[kb+3], BG);
        end
        vs_pulse();
        vs_pulse();
        tick(41, 47, 1'b1, 1'b1, 1'b1);
        kb = last;
        idle(4);
        checks++;
        if (hist_rgb[kb+3] !== FG) begin
            errors++;
            $display("FAIL cursor_blink_on: got %h, want %h", hist_rgb[kb+3], FG);
        end
    endtask

    task automatic test_reset_mid_line();
        int kr;
        vs_pulse();
        vs_pulse();
        for (int x = 0; x < 7; x++) tick(x, 0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== FG || vga_de !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pixel: got rgb=%h de=%b, want %h 1", {vga_r, vga_g, vga_b}, vga_de, FG);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs} !== {24'h0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got rgb=%h de=%b hs=%b vs=%b, want 000000 0 1 1",
                     {vga_r, vga_g, vga_b}, vga_de, vga_hs, vga_vs);
        end
        tick(40, 46, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.text_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL cs_mid_reset: got %b, want 1", bus.text_chipselect);
        end
        tick(41, 46, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b1;
        kr = last;
        tick(42, 46, 1'b1, 1'b1, 1'b1);
        tick(43, 46, 1'b1, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (hist_rgb[kr+1] !== 24'h0 || hist_de[kr+1] !== 1'b0 ||
            hist_rgb[kr+2] !== 24'h0 || hist_de[kr+2] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_stale: got %h/%b %h/%b, want 000000/0 000000/0",
                     hist_rgb[kr+1], hist_de[kr+1], hist_rgb[kr+2], hist_de[kr+2]);
        end
        checks++;
        if (hist_rgb[kr+3] !== FG || hist_de[kr+3] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: got rgb=%h de=%b, want %h 1 (blink phase 1)",
                     hist_rgb[kr+3], hist_de[kr+3], FG);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            text_mem[i] = 8'h00;
            font_mem[i] = 8'h00;
        end
        text_mem[0]     = 8'h41;
        text_mem[2399]  = 8'h41;
        font_mem[12'h410] = 8'h18;
        font_mem[12'h41F] = 8'h81;
        font_mem[12'h415] = 8'hFF;
        bus.text_readdata = 8'h00;
        bus.font_readdata = 8'h00;
        reset_n    = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        de_in      = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;

        test_reset();
        test_char_row();
        test_last_cell();
        test_out_of_range();
        test_sync_delay();
        test_cursor_blink();
        test_reset_mid_line();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
